// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, port ids, counter width.
package memory_arbiter_pkg;

    localparam int unsigned CNT_WIDTH = 3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester winner select. Round-robin on contention unless ARB_FIXED_PRIORITY_EN
// is defined, in which case port 0 always wins and no history is needed.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] req,
`ifndef ARB_FIXED_PRIORITY_EN
    input  logic       lastGrant,
`endif
    output logic       grant_c
);

    always_comb begin
        grant_c = PORT0;
        case (req)
            2'b10:   grant_c = PORT1;
`ifdef ARB_FIXED_PRIORITY_EN
            2'b11:   grant_c = PORT0;
`else
            2'b11:   grant_c = ~lastGrant;
`endif
            default: grant_c = PORT0;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between a fetch port (0) and a load/store port (1).
// Optional build macro: ARB_FIXED_PRIORITY_EN (port 0 always wins contention).
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  grant_id
);

    arb_state_t             state, stateNext;
    logic                   weLat, weNext;
    logic [CNT_WIDTH-1:0]   cnt, cntNext;
    logic                   memReadNext, memWriteNext;
    logic [ADDR_WIDTH-1:0]  memAddrNext;
    logic [DATA_WIDTH-1:0]  memWdataNext;
    logic                   grantNext;
    logic                   ack0Next, ack1Next;
    logic [DATA_WIDTH-1:0]  rdata0Next, rdata1Next;
    logic                   winner_c;
    logic                   selWe;
    logic [ADDR_WIDTH-1:0]  selAddr;
    logic [DATA_WIDTH-1:0]  selWdata;

`ifndef ARB_FIXED_PRIORITY_EN
    logic                   lastGrant, lastGrantNext;
`endif

    rr_arbiter_2 arb (
        .req       ({p1_req, p0_req}),
`ifndef ARB_FIXED_PRIORITY_EN
        .lastGrant (lastGrant),
`endif
        .grant_c   (winner_c)
    );

    assign selWe    = (winner_c == PORT1) ? p1_we    : p0_we;
    assign selAddr  = (winner_c == PORT1) ? p1_addr  : p0_addr;
    assign selWdata = (winner_c == PORT1) ? p1_wdata : p0_wdata;

    // mem_addr/mem_wdata double as the latched request; only we needs its own latch
    always_comb begin
        stateNext    = state;
        weNext       = weLat;
        cntNext      = cnt;
        memReadNext  = 1'b0;
        memWriteNext = 1'b0;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        grantNext    = grant_id;
        ack0Next     = 1'b0;
        ack1Next     = 1'b0;
        rdata0Next   = p0_rdata;
        rdata1Next   = p1_rdata;
`ifndef ARB_FIXED_PRIORITY_EN
        lastGrantNext = lastGrant;
`endif
        case (state)
            ST_IDLE: begin
                grantNext = PORT0;
                if (p0_req || p1_req) begin
                    stateNext    = ST_ACCESS;
                    grantNext    = winner_c;
                    weNext       = selWe;
                    memAddrNext  = selAddr;
                    memWdataNext = selWdata;
                    memWriteNext = selWe;
                    memReadNext  = ~selWe;
`ifndef ARB_FIXED_PRIORITY_EN
                    lastGrantNext = winner_c;
`endif
                end
            end
            ST_ACCESS: begin
                if (weLat) begin
                    stateNext = ST_RESP;
                    ack0Next  = (grant_id == PORT0);
                    ack1Next  = (grant_id == PORT1);
                end else begin
                    stateNext   = ST_WAIT;
                    cntNext     = CNT_WIDTH'(READ_LATENCY);
                    memReadNext = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    stateNext = ST_RESP;
                    ack0Next  = (grant_id == PORT0);
                    ack1Next  = (grant_id == PORT1);
                    if (grant_id == PORT1) rdata1Next = mem_read_data;
                    else                   rdata0Next = mem_read_data;
                end else begin
                    cntNext     = cnt - CNT_WIDTH'(1);
                    memReadNext = 1'b1;
                end
            end
            ST_RESP: begin
                stateNext = ST_IDLE;
                grantNext = PORT0;
            end
            default: begin
                stateNext = ST_IDLE;
                grantNext = PORT0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            weLat     <= 1'b0;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= PORT0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            lastGrant <= PORT1;
`endif
        end else begin
            state     <= stateNext;
            weLat     <= weNext;
            cnt       <= cntNext;
            mem_read  <= memReadNext;
            mem_write <= memWriteNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            grant_id  <= grantNext;
            p0_ack    <= ack0Next;
            p1_ack    <= ack1Next;
            p0_rdata  <= rdata0Next;
            p1_rdata  <= rdata1Next;
`ifndef ARB_FIXED_PRIORITY_EN
            lastGrant <= lastGrantNext;
`endif
        end
    end

endmodule
